// File: rtl/fifo_request_serializer_pkg.sv
// Shared definitions for the request serializer: FSM state encoding and byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_request_serializer_pkg;

  // IDLE: waiting for an upstream entry. SEND: an entry is held and being beaten out.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int BYTE_LEN_IN_BITS = 8;

endpackage

// File: rtl/fifo_request_serializer_beat_shift_register.sv
// Parallel-load right shifter holding one entry; the low beat is always on data_out.
// Latency: load/shift/clear take effect on the next posedge.
// Backpressure: none; it holds its value until told to load, shift or clear.
//
// Ports:
//   clk_in, reset_in   clock, synchronous active-low reset
//   load_in, load_dat  parallel load of a full entry (highest priority)
//   clr_in             zero the register
//   shift_en_in        shift right by one beat, zero fill
//   data_out           current register contents
module fifo_request_serializer_beat_shift_register #(
  parameter int WIDTH_IN_BITS      = 64,
  parameter int BEAT_WIDTH_IN_BITS = 16
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     load_in,
  input  logic [WIDTH_IN_BITS-1:0] load_dat,
  input  logic                     clr_in,
  input  logic                     shift_en_in,
  output logic [WIDTH_IN_BITS-1:0] data_out
);

  logic [WIDTH_IN_BITS-1:0] data_d;
  logic [WIDTH_IN_BITS-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (load_in) begin
      data_d = load_dat;
    end else if (clr_in) begin
      data_d = '0;
    end else if (shift_en_in) begin
      data_d = {{BEAT_WIDTH_IN_BITS{1'b0}}, data_q[WIDTH_IN_BITS-1:BEAT_WIDTH_IN_BITS]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/fifo_request_serializer.sv
// Drains one wide entry from a valid/ack queue and re-emits it as NUM_BEATS narrow beats, LSB beat first.
// Latency: upstream valid sampled at T -> issue_ack_out and beat 0 valid at T+1.
// Backpressure: beats held stable until beat_ack_in; upstream is not acked again until the entry is fully sent.
//
// Option macro FIFO_SERIALIZER_BACK_TO_BACK_EN: when defined, the next beat follows an acked beat
// with no bubble (1 beat/cycle under held ack); otherwise one bubble cycle follows each acked beat.
//
// Ports:
//   clk_in, reset_in                    clock, synchronous active-low reset
//   request_in, request_valid_in        upstream entry and its valid
//   issue_ack_out                       one-cycle registered accept pulse to upstream
//   beat_out, beat_valid_out            downstream beat and its valid
//   beat_last_out                       marks the final beat of an entry
//   beat_ack_in                         downstream accept pulse
//   busy_out                            an entry is held
module fifo_request_serializer
  import fifo_request_serializer_pkg::*;
#(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int BEAT_WIDTH_IN_BITS         = 16,
  parameter int NUM_BEATS                  = SINGLE_ENTRY_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS,
  parameter int BEAT_CNT_WIDTH_IN_BITS     = $clog2(NUM_BEATS)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [BEAT_WIDTH_IN_BITS-1:0]         beat_out,
  output logic                                  beat_valid_out,
  output logic                                  beat_last_out,
  input  logic                                  beat_ack_in,
  output logic                                  busy_out
);

  state_e                              state_d, state_q;
  logic [BEAT_CNT_WIDTH_IN_BITS-1:0]   cnt_d, cnt_q;
  logic                                issue_ack_d, issue_ack_q;
  logic                                beat_valid_d, beat_valid_q;
  logic                                sr_load, sr_shift, sr_clr;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] sr_data;
  logic                                cnt_is_last;
  logic                                beat_taken;

  assign cnt_is_last = (cnt_q == BEAT_CNT_WIDTH_IN_BITS'(NUM_BEATS - 1));
  // An ack only counts while a beat is actually offered.
  assign beat_taken  = beat_ack_in & beat_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    issue_ack_d  = 1'b0;
    beat_valid_d = beat_valid_q;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The issue_ack_q guard keeps the accept pulse from ever repeating back to back.
        if (request_valid_in && !issue_ack_q) begin
          sr_load      = 1'b1;
          issue_ack_d  = 1'b1;
          cnt_d        = '0;
          beat_valid_d = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_taken) begin
          if (cnt_is_last) begin
            cnt_d        = '0;
            sr_clr       = 1'b1;
            beat_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            sr_shift     = 1'b1;
            cnt_d        = cnt_q + BEAT_CNT_WIDTH_IN_BITS'(1);
`ifdef FIFO_SERIALIZER_BACK_TO_BACK_EN
            beat_valid_d = 1'b1;
`else
            beat_valid_d = 1'b0;
`endif
          end
        end else if (!beat_valid_q) begin
          // Bubble cycle over: offer the already-shifted next beat.
          beat_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      issue_ack_q  <= 1'b0;
      beat_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      issue_ack_q  <= issue_ack_d;
      beat_valid_q <= beat_valid_d;
    end
  end

  fifo_request_serializer_beat_shift_register #(
    .WIDTH_IN_BITS      (SINGLE_ENTRY_WIDTH_IN_BITS),
    .BEAT_WIDTH_IN_BITS (BEAT_WIDTH_IN_BITS)
  ) u_beat_shift_register (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .load_in     (sr_load),
    .load_dat    (request_in),
    .clr_in      (sr_clr),
    .shift_en_in (sr_shift),
    .data_out    (sr_data)
  );

  assign issue_ack_out  = issue_ack_q;
  assign beat_out       = sr_data[BEAT_WIDTH_IN_BITS-1:0];
  assign beat_valid_out = beat_valid_q;
  assign beat_last_out  = beat_valid_q & cnt_is_last;
  assign busy_out       = (state_q == ST_SEND);

endmodule
